// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program-memory sequencer.
package seq_pkg;
   localparam int MEM_DEPTH = 256;
   localparam int ADDR_W    = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      HALT = 3'd4
   } state_t;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] satInc(input logic [31:0] val, input int width);
      logic [31:0] maxVal;
      maxVal = 32'hFFFF_FFFF >> (32 - width);
      return (val >= maxVal) ? val : val + 32'd1;
   endfunction
endpackage

// File: rtl/prog_sequencer_if.sv
// Host load stream, run-control pulses and CPU-facing signals of the sequencer.
interface prog_sequencer_if #(
   parameter int CYC_W = 16
);
   logic             load_start;
   logic [7:0]       load_len;
   logic             ld_valid;
   logic [7:0]       ld_data;
   logic             ld_ready;
   logic             run;
   logic             step;
   logic             halt_req;
   logic [7:0]       cpu_addr;
   logic [7:0]       cpu_instr;
   logic             cpu_en;
   logic [2:0]       state;
   logic [8:0]       prog_len;
   logic [CYC_W-1:0] cycles;

   modport master (
      output load_start, load_len, ld_valid, ld_data, run, step, halt_req, cpu_addr,
      input  ld_ready, cpu_instr, cpu_en, state, prog_len, cycles
   );

   modport slave (
      input  load_start, load_len, ld_valid, ld_data, run, step, halt_req, cpu_addr,
      output ld_ready, cpu_instr, cpu_en, state, prog_len, cycles
   );
endinterface

// File: rtl/prog_sequencer_mem.sv
// Instruction store: synchronous write, combinational read, contents never reset.
module prog_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/prog_sequencer.sv
// Loads a program into the instruction store, then feeds the CPU and gates it
// with a clock enable under run / single-step / halt control.
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int MEM_DEPTH = seq_pkg::MEM_DEPTH,
   parameter int CYC_W     = 16
) (
   input logic             clk,
   input logic             rst,
   prog_sequencer_if.slave bus
);
   state_t           stQ, stD;
   logic [8:0]       lenQ;
   logic [7:0]       wptrQ;
   logic             loadedQ;
   logic             ldReadyQ;
   logic [CYC_W-1:0] cycQ;

   logic       inRange, lastByte, cpuEn;
   logic       startLoad, wr, setLoaded, clrLoaded;
   logic [7:0] rdData;

   assign inRange  = {1'b0, bus.cpu_addr} < lenQ;
   assign lastByte = {1'b0, wptrQ} == (lenQ - 9'd1);

   always_comb begin
      stD       = stQ;
      cpuEn     = 1'b0;
      startLoad = 1'b0;
      wr        = 1'b0;
      setLoaded = 1'b0;
      clrLoaded = 1'b0;
      unique case (stQ)
         IDLE, HALT: begin
            // halt_req outranks every other command, so it simply blocks them here
            if (!bus.halt_req) begin
               if (bus.load_start) begin
                  startLoad = 1'b1;
                  stD       = LOAD;
               end else if (loadedQ && bus.run) begin
                  stD = RUN;
               end else if (loadedQ && bus.step) begin
                  stD = STEP;
               end
            end
         end
         LOAD: begin
            if (bus.halt_req) begin
               clrLoaded = 1'b1;
               stD       = IDLE;
            end else if (bus.ld_valid) begin
               wr = 1'b1;
               if (lastByte) begin
                  setLoaded = 1'b1;
                  stD       = IDLE;
               end
            end
         end
         RUN: begin
            if (bus.halt_req) begin
               stD = HALT;
            end else begin
               cpuEn = inRange;
               if (!inRange) stD = HALT;
            end
         end
         STEP: begin
            cpuEn = inRange && !bus.halt_req;
            stD   = HALT;
         end
         default: stD = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stQ      <= IDLE;
         lenQ     <= 9'd0;
         wptrQ    <= 8'd0;
         loadedQ  <= 1'b0;
         ldReadyQ <= 1'b0;
         cycQ     <= '0;
      end else begin
         stQ      <= stD;
         ldReadyQ <= (stD == LOAD);
         if (startLoad) begin
            // a zero length means a full 256-byte image
            lenQ    <= (bus.load_len == 8'd0) ? 9'd256 : {1'b0, bus.load_len};
            wptrQ   <= 8'd0;
            cycQ    <= '0;
            loadedQ <= 1'b0;
         end
         if (wr)        wptrQ   <= wptrQ + 8'd1;
         if (setLoaded) loadedQ <= 1'b1;
         if (clrLoaded) loadedQ <= 1'b0;
         if (cpuEn)     cycQ    <= CYC_W'(satInc(32'(cycQ), CYC_W));
      end
   end

   prog_mem #(.DEPTH(MEM_DEPTH), .AW(ADDR_W)) uMem (
      .clk   (clk),
      .we    (wr),
      .waddr (wptrQ),
      .wdata (bus.ld_data),
      .raddr (bus.cpu_addr),
      .rdata (rdData)
   );

   assign bus.ld_ready  = ldReadyQ;
   assign bus.cpu_en    = cpuEn;
   assign bus.cpu_instr = (stQ == RUN || stQ == STEP) ? rdData : 8'h00;
   assign bus.state     = stQ;
   assign bus.prog_len  = lenQ;
   assign bus.cycles    = cycQ;
endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench: stimulus pushes expected outputs from a rule-level model,
// a negedge monitor pops and compares them against the sequencer.
module tb_prog_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prog_sequencer_if #(.CYC_W(16)) bus ();
   prog_sequencer #(.MEM_DEPTH(256), .CYC_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        ready;
      logic        en;
      logic [7:0]  instr;
      logic [2:0]  st;
      logic [8:0]  len;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   passCnt = 0, failCnt = 0, checkCnt = 0;
   int   hsCnt = 0, hsExp = 0, hsReqN = 0, hsDoneN = 0;
   bit   endReq = 0, endDone = 0;

   // reference model: program image, mode name and counters
   logic [7:0] mMem [256];
   int         mMode;   // 0 idle,1 load,2 run,3 step,4 halt
   int         mLen, mWptr, mCyc;
   bit         mLoaded;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else begin
         failCnt++;
         $display("FAIL %s @%0t got=%h exp=%h", name, $time, act, exp);
      end
   endtask

   task automatic startLoad(input logic [7:0] ll);
      mLen    = (ll == 0) ? 256 : int'(ll);
      mWptr   = 0;
      mCyc    = 0;
      mLoaded = 0;
      mMode   = 1;
   endtask

   task automatic model(input bit r, ls, input logic [7:0] ll, input bit v,
                        input logic [7:0] d, input bit ru, sp, hq, input logic [7:0] a);
      exp_t e;
      bit   executing, inR;
      if (r) begin
         mMode = 0; mLen = 0; mWptr = 0; mCyc = 0; mLoaded = 0;
      end
      executing = (mMode == 2 || mMode == 3);
      inR       = int'(a) < mLen;
      e.ready   = (mMode == 1);
      e.en      = executing && inR && !hq;
      e.instr   = executing ? mMem[a] : 8'h00;
      e.st      = 3'(mMode);
      e.len     = 9'(mLen);
      e.cnt     = 16'(mCyc);
      sb.push_back(e);
      if (r) return;
      if (e.en && mCyc < 65535) mCyc++;
      case (mMode)
         0, 4: if (!hq) begin
            if (ls) startLoad(ll);
            else if (mLoaded && ru) mMode = 2;
            else if (mLoaded && sp) mMode = 3;
         end
         1: if (hq) begin
            mMode = 0; mLoaded = 0;
         end else if (v) begin
            mMem[mWptr] = d;
            if (mWptr == mLen - 1) begin mMode = 0; mLoaded = 1; end
            mWptr = (mWptr + 1) % 256;
         end
         2: if (hq || !inR) mMode = 4;
         3: mMode = 4;
         default: mMode = 0;
      endcase
   endtask

   task automatic tick(input bit r = 0, input bit ls = 0, input logic [7:0] ll = 0,
                       input bit v = 0, input logic [7:0] d = 0, input bit ru = 0,
                       input bit sp = 0, input bit hq = 0, input logic [7:0] a = 0);
      rst            = r;
      bus.load_start = ls;
      bus.load_len   = ll;
      bus.ld_valid   = v;
      bus.ld_data    = d;
      bus.run        = ru;
      bus.step       = sp;
      bus.halt_req   = hq;
      bus.cpu_addr   = a;
      model(r, ls, ll, v, d, ru, sp, hq, a);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.ld_valid && bus.ld_ready) hsCnt++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("ld_ready", 16'(bus.ld_ready), 16'(e.ready));
         chk("cpu_en",   16'(bus.cpu_en),   16'(e.en));
         if (!$isunknown(e.instr)) chk("cpu_instr", 16'(bus.cpu_instr), 16'(e.instr));
         chk("state",    16'(bus.state),    16'(e.st));
         chk("prog_len", 16'(bus.prog_len), 16'(e.len));
         chk("cycles",   bus.cycles,        e.cnt);
      end
      if (hsReqN != hsDoneN) begin
         chk("handshakes", 16'(hsCnt), 16'(hsExp));
         hsDoneN = hsReqN;
      end
      if (endReq && !endDone) begin
         chk("scoreboard_drain", 16'(sb.size()), 16'd0);
         endDone = 1;
      end
   end

   logic [7:0] img4 [4];

   initial begin
      img4[0] = 8'h05; img4[1] = 8'h4A; img4[2] = 8'h91; img4[3] = 8'hC3;
      bus.load_start = 0; bus.load_len = 0; bus.ld_valid = 0; bus.ld_data = 0;
      bus.run = 0; bus.step = 0; bus.halt_req = 0; bus.cpu_addr = 0;
      @(posedge clk); #1;
      tick(.r(1)); tick(.r(1));

      // four-byte back-to-back load, then read each byte back by stepping
      tick(.ls(1), .ll(8'd4));
      for (int i = 0; i < 4; i++) tick(.v(1), .d(img4[i]));
      tick(); tick(.v(1), .d(8'hEE));
      hsExp = 4; hsReqN++;
      for (int i = 0; i < 4; i++) begin
         tick(.sp(1)); tick(.a(8'(i))); tick(.a(8'(i)));
      end

      // full 256-byte load with a stalling host
      tick(.ls(1), .ll(8'd0));
      for (int i = 0; i < 600 && mMode == 1; i++) tick(.v(i % 2 == 1), .d(8'($urandom)));
      tick(); tick();
      hsExp = 260; hsReqN++;
      tick(.ru(1));
      for (int i = 0; i < 256; i++) tick(.a(8'($urandom_range(0, 255))));
      tick(.hq(1), .a(8'd0)); tick();

      // three-byte program runs off its end
      tick(.ls(1), .ll(8'd3));
      for (int i = 0; i < 3; i++) tick(.v(1), .d(8'($urandom)));
      tick(.ru(1));
      for (int i = 0; i < 4; i++) tick(.a(8'(i)));
      tick(); tick();

      // two single steps at address 1
      for (int k = 0; k < 2; k++) begin
         tick(.sp(1), .a(8'd1)); tick(.a(8'd1)); tick(.a(8'd1));
      end

      // halt beats run; halt mid-run drops the enable immediately
      tick(.hq(1), .ru(1)); tick(.a(8'd0)); tick(.a(8'd1));
      tick(.ru(1)); tick(.a(8'd0)); tick(.a(8'd1)); tick(.hq(1), .a(8'd2)); tick(.a(8'd0));

      // reset during a partial load, run is then refused until a fresh load
      tick(.ls(1), .ll(8'd5));
      tick(.v(1), .d(8'h11)); tick(.v(1), .d(8'h22));
      tick(.r(1), .v(1), .d(8'h33)); tick(.r(1));
      tick(.ru(1)); tick(.a(8'd0)); tick(.sp(1)); tick(.a(8'd0));
      tick(.ls(1), .ll(8'd2)); tick(.v(1), .d(8'hA5)); tick(.v(1), .d(8'h5A));
      tick(.ru(1)); tick(.a(8'd0)); tick(.a(8'd1)); tick(.a(8'd2)); tick();

      // randomized command mix
      for (int i = 0; i < 3000; i++) begin
         int hi;
         hi = (mLen + 2 > 255) ? 255 : mLen + 2;
         tick(.r($urandom_range(0, 999) < 2),
              .ls($urandom_range(0, 99) < 3), .ll(8'($urandom_range(0, 12))),
              .v($urandom_range(0, 9) < 6), .d(8'($urandom)),
              .ru($urandom_range(0, 99) < 4), .sp($urandom_range(0, 99) < 4),
              .hq($urandom_range(0, 99) < 2), .a(8'($urandom_range(0, hi))));
      end
      tick();
      endReq = 1;
      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-memory controller and run sequencer for the 8-bit CPU core. It accepts a program from a host over a valid/ready byte stream and stores it in a 256×8 instruction store. It then drives the CPU's `instruction` input from `next_addr` and gates CPU progress with a clock enable, supporting run, single-step and halt. It sits between the host/testbench and the CPU, and is the only writer of instruction memory.

## Interface
Parameters:
- `MEM_DEPTH`, 256: instruction store depth; address width fixed at 8.
- `CYC_W`, 16: width of the executed-cycle counter.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle pulse; begins a program load.
- `load_len`  in  8  byte count for the load, sampled with `load_start`; 0 means 256.
- `ld_valid`  in  1  host byte valid.
- `ld_data`  in  8  host byte.
- `ld_ready`  out  1  sequencer accepts byte.
- `run`  in  1  pulse; start free-running execution.
- `step`  in  1  pulse; execute exactly one CPU cycle.
- `halt_req`  in  1  pulse; stop execution.
- `cpu_addr`  in  8  CPU `next_addr`.
- `cpu_instr`  out  8  instruction to CPU.
- `cpu_en`  out  1  CPU clock enable; the CPU advances only on cycles where it is 1.
- `state`  out  3  encoded FSM state.
- `prog_len`  out  9  length of loaded program, 1..256.
- `cycles`  out  CYC_W  count of cycles with `cpu_en`=1.

## Operation
- FSM states: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- IDLE:
  - `load_start` → LOAD; sets `prog_len`, clears write pointer `wptr`, clears `cycles`.
  - `run`/`step` from IDLE are ignored unless a program is loaded (`loaded` flag=1).
- LOAD:
  - `ld_ready`=1.
  - On each cycle with `ld_valid&ld_ready`: write `mem[wptr]`=`ld_data`, `wptr`++ (8-bit).
  - On the final byte (`wptr`==`prog_len`-1) → IDLE and set `loaded`=1.
  - In LOAD, `run`/`step`/`load_start` are ignored. `halt_req` aborts → IDLE with `loaded`=0.
- RUN: `cpu_en` = `in_range`, where `in_range` = (`cpu_addr` < `prog_len`). When `in_range`=0, `cpu_en`=0 that same cycle and state → HALT.
- STEP: `cpu_en` = `in_range` for exactly one cycle, then → HALT.
- HALT:
  - `run` → RUN; `step` → STEP; `load_start` → LOAD.
  - CPU register state is untouched; the sequencer never resets the CPU.
- Command priority when several arrive in the same cycle: `halt_req` > `load_start` > `run` > `step`. In RUN/STEP, `halt_req` → HALT and forces `cpu_en`=0 that cycle.
- `cpu_instr` = `mem[cpu_addr]` (combinational read) in RUN/STEP; 8'h00 in all other states.
- `cycles` increments on every `cpu_en`=1 cycle and saturates at all-ones (no wrap).
- Memory contents are not reset; only the `loaded` flag is.

## Timing
- Reset values:
  - `state`=IDLE, `ld_ready`=0, `cpu_en`=0, `cpu_instr`=0.
  - `prog_len`=0, `cycles`=0, `loaded`=0, `wptr`=0.
- Reset is asynchronous assert, synchronous deassert at the system level. Reset mid-LOAD discards the partial load (`loaded`=0).
- `ld_ready` is a registered state decode: 1 from the cycle after `load_start` until the cycle after the last accepted byte. Throughput is one byte per cycle; host stalls (`ld_valid`=0) are allowed indefinitely.
- `run` pulse at edge N → `cpu_en`=1 from cycle N+1.
- `step` at edge N → `cpu_en`=1 during cycle N+1 only.
- Reads are combinational: a `cpu_addr` change is reflected in `cpu_instr` in the same cycle. A write and a read never overlap because they occur in different states.

## Structure
- Package `seq_pkg`:
  - `state_t` enum (3-bit) with the encodings above.
  - `MEM_DEPTH` and `ADDR_W`=8 constants.
  - Cycle-counter saturate helper function.
- One sub-module, `prog_mem`: 256×8 array, synchronous write port (`we`, `waddr`, `wdata`), asynchronous read port. No reset on the array.
- The FSM, pointer, counter and command decode live in `prog_sequencer`.

## Test plan
- Load 4 bytes {8'h05, 8'h4A, 8'h91, 8'hC3} with back-to-back `ld_valid`. Required: 4 handshakes; return to IDLE; `prog_len`=4; `mem[0..3]` match; `ld_ready` low afterwards.
- Load with `ld_valid` toggling every other cycle and `load_len`=0. Required: exactly 256 bytes accepted; `wptr` wraps to 0; `prog_len`=256.
- `run` after loading 3 bytes, with `cpu_addr` driven 0,1,2,3. Required: `cpu_en`=1 for 3 cycles; 0 at addr 3; state=HALT; `cycles`=3.
- From HALT, apply `step` twice with `cpu_addr`=1. Required: two single-cycle `cpu_en` pulses; `cpu_instr`=`mem[1]` during each pulse and 0 otherwise.
- `halt_req` and `run` in the same cycle from HALT. Required: stays in HALT with `cpu_en`=0. `halt_req` mid-RUN: `cpu_en` drops in the same cycle.
- Assert `rst` after 2 of 5 bytes of a load. Required: all outputs return to reset values asynchronously; `run` is then ignored until a new load completes.
